demux16_12_buf: RTL

- Buffered 1:2 demultiplexer: the inverse of the datapath's 16-bit 2:1 select.
- Takes one 16-bit word stream with a select bit and steers each word to output A (sel=0) or output B (sel=1).
- Each output has its own small synchronous FIFO and a valid/ready handshake.
- Sits in the write-back path, splitting ALU/load results between the register-file write port and the memory/store path without stalling on the idle destination.

---
 rtl/datapath_pkg.sv | 14 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/demux16_12_buf.sv | 68 ++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath constants and helpers
package datapath_pkg;

  localparam int DATA_W = 16;

  // Select polarity matches the datapath's 2:1 mux.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered count/full/empty
module sync_fifo
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard internally so a misbehaving caller can never over/underflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/demux16_12_buf.sv
// rtl/demux16_12_buf.sv - buffered 1:2 word demultiplexer with per-output FIFOs
module demux16_12_buf
  import datapath_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sel,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  logic             a_full, b_full;
  logic             a_empty, b_empty;
  logic             a_push, b_push;
  logic             a_pop, b_pop;
  logic [WIDTH-1:0] a_dout, b_dout;

  // Ready depends only on registered full flags, never on downstream ready.
  assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;

  assign a_push = in_valid && in_ready && (in_sel == SEL_A);
  assign b_push = in_valid && in_ready && (in_sel == SEL_B);

  assign a_valid = !a_empty;
  assign b_valid = !b_empty;
  assign a_pop   = a_valid && a_ready;
  assign b_pop   = b_valid && b_ready;

  assign a_data = a_valid ? a_dout : '0;
  assign b_data = b_valid ? b_dout : '0;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_push),
    .pop   (a_pop),
    .din   (in_data),
    .dout  (a_dout),
    .count (a_count),
    .full  (a_full),
    .empty (a_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_push),
    .pop   (b_pop),
    .din   (in_data),
    .dout  (b_dout),
    .count (b_count),
    .full  (b_full),
    .empty (b_empty)
  );

endmodule
